// File: rtl/alu_sched_pkg.sv
// Shared definitions for the round-robin ALU scheduler: opcode encoding,
// FSM states and the carry-qualifying helper.
package alu_sched_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_SHR  = 3'd5;
    localparam logic [2:0] OP_SHL  = 3'd6;
    localparam logic [2:0] OP_ADD2 = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Only the arithmetic ops produce a meaningful carry/borrow.
    function automatic logic op_has_carry(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADD2);
    endfunction

endpackage

// File: rtl/alu_rr_scheduler_arbiter.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to
// the side named by the priority pointer.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (&valid) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one external combinational ALU between two requesters; each op is
// latched, executed for one cycle and returned on a tagged response channel.
//
//   state | meaning
//   IDLE  | waiting for a request; ready shown to the granted port
//   EXEC  | latched operands drive the ALU; result captured at the edge
//   RESP  | response held until rsp_ready, then pointer moves past winner
module alu_rr_scheduler
    import alu_sched_pkg::*;
#(
    parameter int N   = 4,
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           rst_n,

    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [N-1:0]   req0_a,
    input  logic [N-1:0]   req0_b,
    input  logic [OPW-1:0] req0_op,
    input  logic           req0_cin,

    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [N-1:0]   req1_a,
    input  logic [N-1:0]   req1_b,
    input  logic [OPW-1:0] req1_op,
    input  logic           req1_cin,

    output logic [N-1:0]   alu_a,
    output logic [N-1:0]   alu_b,
    output logic [OPW-1:0] alu_select,
    output logic           alu_cin,
    input  logic [N-1:0]   alu_s,
    input  logic           alu_cout,

    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [N-1:0]   rsp_s,
    output logic           rsp_cout,
    output logic           rsp_zero
);

    state_t         state_q, state_d;
    logic           ptr_q;
    logic [1:0]     grant;
    logic           accept;

    logic [N-1:0]   a_q, b_q;
    logic [OPW-1:0] op_q;
    logic           cin_q;
    logic           id_q;

    logic [N-1:0]   s_q;
    logic           cout_q;
    logic           zero_q;

    rr_arbiter2 u_arb (
        .valid (  {req1_valid, req0_valid}),
        .ptr   (ptr_q),
        .grant (grant)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC:    state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gated by rst_n so a requester held valid through reset never sees ready.
    assign req0_ready = accept & grant[0] & rst_n;
    assign req1_ready = accept & grant[1] & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cin_q   <= 1'b0;
            id_q    <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                id_q  <= grant[1];
                a_q   <= grant[1] ? req1_a   : req0_a;
                b_q   <= grant[1] ? req1_b   : req0_b;
                op_q  <= grant[1] ? req1_op  : req0_op;
                cin_q <= grant[1] ? req1_cin : req0_cin;
            end
            if (state_q == EXEC) begin
                s_q    <= alu_s;
                zero_q <= (alu_s == '0);
                cout_q <= op_has_carry(op_q) & alu_cout;
            end
            if ((state_q == RESP) && rsp_ready) begin
                ptr_q <= ~id_q;
            end
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_select = op_q;
    assign alu_cin    = cin_q;

    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_s      = s_q;
    assign rsp_cout   = cout_q;
    assign rsp_zero   = zero_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench for alu_rr_scheduler: behavioural model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_alu_rr_scheduler;

    localparam int N   = 4;
    localparam int OPW = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req0_valid, req0_ready, req0_cin;
    logic [N-1:0]   req0_a, req0_b;
    logic [OPW-1:0] req0_op;
    logic           req1_valid, req1_ready, req1_cin;
    logic [N-1:0]   req1_a, req1_b;
    logic [OPW-1:0] req1_op;
    logic [N-1:0]   alu_a, alu_b, alu_s;
    logic [OPW-1:0] alu_select;
    logic           alu_cin, alu_cout;
    logic           rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_zero;
    logic [N-1:0]   rsp_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_rr_scheduler #(.N(N), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_op(req0_op), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_op(req1_op), .req1_cin(req1_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_cin(alu_cin),
        .alu_s(alu_s), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_s(rsp_s), .rsp_cout(rsp_cout), .rsp_zero(rsp_zero)
    );

    // Lab ALU: logic and shift ops report carry=1 so the scheduler's masking is exercised.
    function automatic logic [N:0] alu_fn(input logic [2:0] op, input logic [N-1:0] a,
                                          input logic [N-1:0] b, input logic cin);
        logic [N:0] ax, bx, cx;
        ax = {1'b0, a};
        bx = {1'b0, b};
        cx = {{N{1'b0}}, cin};
        case (op)
            3'd0:       return {1'b1, a & b};
            3'd1:       return {1'b1, a | b};
            3'd2:       return {1'b1, a ^ b};
            3'd3, 3'd7: return ax + bx + cx;
            3'd4:       return ax - bx - cx;
            3'd5:       return {1'b1, a >> 1};
            default:    return {1'b1, a << 1};
        endcase
    endfunction

    always_comb begin
        {alu_cout, alu_s} = alu_fn(alu_select, alu_a, alu_b, alu_cin);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model, checked on every falling edge ----------------
    bit           m_busy;
    int           m_cnt;
    logic         m_ptr, m_id, m_cin, m_cout, m_zero;
    logic [N-1:0] m_a, m_b, m_s;
    logic [2:0]   m_op;
    logic         e_r0, e_r1;
    logic [N:0]   m_r;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_cnt = 0; m_ptr = 0; m_id = 0; m_cin = 0;
            m_a = '0; m_b = '0; m_op = '0; m_s = '0; m_cout = 0; m_zero = 0;
            chk("rst_ready0", req0_ready, 0);
            chk("rst_ready1", req1_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_bus", {rsp_id, rsp_cout, rsp_zero, rsp_s}, 0);
            chk("rst_alu_bus", {alu_cin, alu_select, alu_a, alu_b}, 0);
        end else begin
            e_r0 = 0;
            e_r1 = 0;
            if (!m_busy) begin
                if (req0_valid && req1_valid) begin
                    e_r0 = !m_ptr;
                    e_r1 = m_ptr;
                end else begin
                    e_r0 = req0_valid;
                    e_r1 = req1_valid;
                end
            end
            chk("m_ready0", req0_ready, e_r0);
            chk("m_ready1", req1_ready, e_r1);
            chk("m_rsp_valid", rsp_valid, m_busy && m_cnt == 0);
            chk("m_alu_bus", {alu_cin, alu_select, alu_a, alu_b}, {m_cin, m_op, m_a, m_b});
            if (m_busy && m_cnt == 0) begin
                chk("m_rsp_id", rsp_id, m_id);
                chk("m_rsp_s", rsp_s, m_s);
                chk("m_rsp_cout", rsp_cout, m_cout);
                chk("m_rsp_zero", rsp_zero, m_zero);
            end
            if (!m_busy) begin
                if (e_r0 || e_r1) begin
                    m_busy = 1;
                    m_cnt  = 1;
                    m_id   = e_r1;
                    m_a    = e_r1 ? req1_a   : req0_a;
                    m_b    = e_r1 ? req1_b   : req0_b;
                    m_op   = e_r1 ? req1_op  : req0_op;
                    m_cin  = e_r1 ? req1_cin : req0_cin;
                end
            end else if (m_cnt > 0) begin
                m_cnt--;
                m_r    = alu_fn(m_op, m_a, m_b, m_cin);
                m_s    = m_r[N-1:0];
                m_zero = (m_s == 0);
                m_cout = (m_op == 3 || m_op == 4 || m_op == 7) ? m_r[N] : 1'b0;
            end else if (rsp_ready) begin
                m_busy = 0;
                m_ptr  = !m_id;
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int port, input logic [2:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic cin);
        if (port == 0) begin
            req0_op = op; req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1;
        end else begin
            req1_op = op; req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1;
        end
    endtask

    task automatic issue(input int port, input logic [2:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic cin);
        logic got;
        got = 0;
        drive(port, op, a, b, cin);
        for (int i = 0; i < 30; i++) begin
            #1;
            if ((port == 0 && req0_ready) || (port == 1 && req1_ready)) begin
                got = 1;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
        end
        if (port == 0) req0_valid = 0; else req1_valid = 0;
        chk("issue_accepted", got, 1);
    endtask

    task automatic get_rsp(output logic id, output logic [N-1:0] s, output logic c, output logic z);
        logic got;
        got = 0; id = 0; s = '0; c = 0; z = 0;
        for (int i = 0; i < 30; i++) begin
            if (rsp_valid && rsp_ready) begin
                got = 1;
                id = rsp_id; s = rsp_s; c = rsp_cout; z = rsp_zero;
                tick();
                break;
            end
            tick();
        end
        chk("rsp_seen", got, 1);
    endtask

    logic         r_id, r_c, r_z;
    logic [N-1:0] r_s;
    logic         h_id, h_c, h_z;
    logic [N-1:0] h_s;
    int           ids[6];
    int           exp_ids[6] = '{0, 1, 0, 1, 0, 1};
    int           nrsp;

    initial begin
        rst_n = 0;
        rsp_ready = 1;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = '0; req1_cin = 0;
        drive(0, 3'd3, 4'h9, 4'h8, 0);

        // reset held with req0 valid, then release
        repeat (3) tick();
        chk("lit_rst_ready0", req0_ready, 0);
        rst_n = 1;
        #1;
        chk("lit_first_idle_ready0", req0_ready, 1);
        tick();
        req0_valid = 0;
        chk("lit_exec_no_valid", rsp_valid, 0);
        tick();
        chk("lit_add_valid", rsp_valid, 1);
        chk("lit_add_id", rsp_id, 0);
        chk("lit_add_s", rsp_s, 4'h1);
        chk("lit_add_cout", rsp_cout, 1);
        chk("lit_add_zero", rsp_zero, 0);
        tick();

        // XOR with ALU carry forced high
        issue(1, 3'd2, 4'hA, 4'hA, 1);
        get_rsp(r_id, r_s, r_c, r_z);
        chk("lit_xor_id", r_id, 1);
        chk("lit_xor_s", r_s, 0);
        chk("lit_xor_zero", r_z, 1);
        chk("lit_xor_cout", r_c, 0);

        // fairness with both ports continuously valid
        drive(0, 3'd3, 4'h1, 4'h2, 0);
        drive(1, 3'd1, 4'h3, 4'h4, 0);
        nrsp = 0;
        for (int i = 0; i < 60 && nrsp < 6; i++) begin
            if (rsp_valid && rsp_ready) begin
                ids[nrsp] = int'(rsp_id);
                nrsp++;
            end
            tick();
        end
        req0_valid = 0;
        req1_valid = 0;
        chk("lit_fair_count", nrsp, 6);
        for (int k = 0; k < 6; k++) chk($sformatf("lit_fair_id%0d", k), ids[k], exp_ids[k]);

        // response stall for 5 cycles with another request pending
        rsp_ready = 0;
        issue(0, 3'd0, 4'hC, 4'h6, 0);
        drive(1, 3'd4, 4'h5, 4'h3, 0);
        for (int i = 0; i < 10 && !rsp_valid; i++) tick();
        h_id = rsp_id; h_s = rsp_s; h_c = rsp_cout; h_z = rsp_zero;
        chk("lit_stall_s", h_s, 4'h4);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", rsp_valid, 1);
            chk("stall_hold", {rsp_id, rsp_s, rsp_cout, rsp_zero}, {h_id, h_s, h_c, h_z});
            chk("stall_ready", {req0_ready, req1_ready}, 2'b00);
        end
        rsp_ready = 1;
        tick();
        chk("lit_post_stall_idle", rsp_valid, 0);
        chk("lit_post_stall_ready1", req1_ready, 1);
        tick();
        req1_valid = 0;
        get_rsp(r_id, r_s, r_c, r_z);
        chk("lit_sub_id", r_id, 1);
        chk("lit_sub_s", r_s, 4'h2);
        chk("lit_sub_cout", r_c, 0);

        // reset during EXEC of a SUB aborts it and returns pointer to 0
        issue(0, 3'd1, 4'h1, 4'h2, 0);
        get_rsp(r_id, r_s, r_c, r_z);
        issue(1, 3'd4, 4'h3, 4'h7, 1);
        rst_n = 0;
        tick();
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            chk("abort_no_rsp", rsp_valid, 0);
            tick();
        end
        drive(0, 3'd6, 4'h3, 4'h0, 0);
        drive(1, 3'd5, 4'h8, 4'h0, 0);
        #1;
        chk("lit_ptr_reset_r0", req0_ready, 1);
        chk("lit_ptr_reset_r1", req1_ready, 0);
        tick();
        req0_valid = 0;
        req1_valid = 0;
        get_rsp(r_id, r_s, r_c, r_z);
        chk("lit_shl_s", r_s, 4'h6);
        chk("lit_shl_cout", r_c, 0);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_a = N'($urandom); req0_b = N'($urandom);
            req0_op = OPW'($urandom); req0_cin = 1'($urandom);
            req1_a = N'($urandom); req1_b = N'($urandom);
            req1_op = OPW'($urandom); req1_cin = 1'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req0_valid = 0;
        req1_valid = 0;
        rsp_ready = 1;
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
